switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer_pkg.sv | 19 +
 rtl/switch_debouncer_channel.sv | 79 +++++++
 rtl/switch_debouncer.sv | 40 ++++
 tb/tb_switch_debouncer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared types and default constants for the multi-channel switch debouncer.
// Channels settle independently; the top only aggregates their status.
package switch_debouncer_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } ch_state_e;

    localparam int DEF_WIDTH        = 4;
    localparam int DEF_DEBOUNCE_CNT = 500000;   // 10 ms at 50 MHz
    localparam int DEF_CNT_W        = 20;

    // Terminal counter value: the settle completes on the edge the counter sits here.
    function automatic int last_count(input int debounce_cnt);
        return debounce_cnt - 1;
    endfunction

endpackage

// File: rtl/switch_debouncer_channel.sv
// One debounce channel: two-flop synchronizer, STABLE/SETTLING FSM with a
// saturating settle counter, registered level and one-cycle edge pulses.
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int   DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int   CNT_W        = DEF_CNT_W,
    parameter logic INIT_BIT     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic settling
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(last_count(DEBOUNCE_CNT));

    logic             sync1;
    logic             sync2;
    ch_state_e        state;
    logic [CNT_W-1:0] cnt;

    // raw is asynchronous to clk; nothing else may look at it before sync2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= INIT_BIT;
            sync2 <= INIT_BIT;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= STABLE;
            cnt   <= '0;
            level <= INIT_BIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE: begin
                    cnt <= '0;
                    if (sync2 != level) begin
                        state <= SETTLING;
                    end
                end
                SETTLING: begin
                    if (sync2 == level) begin
                        // Bounced back before the settle time elapsed: discard.
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        level <= sync2;
                        rise  <= sync2;
                        fall  <= ~sync2;
                        state <= STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign settling = (state == SETTLING);

endmodule

// File: rtl/switch_debouncer.sv
// WIDTH independent switch debouncers; busy reports any channel mid-settle.
// sw_out feeds the PIO in_port, so post-reset settles appear there as edges.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int               CNT_W        = DEF_CNT_W,
    parameter logic [WIDTH-1:0] INIT_VAL     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             busy
);

    logic [WIDTH-1:0] settling;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .CNT_W        (CNT_W),
            .INIT_BIT     (INIT_VAL[i])
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw      (raw_in[i]),
            .level    (sw_out[i]),
            .rise     (sw_rise[i]),
            .fall     (sw_fall[i]),
            .settling (settling[i])
        );
    end

    assign busy = |settling;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: a window model of raw samples predicts every cycle's outputs;
// a monitor pops and compares each cycle, plus directed latency checks.
module tb_switch_debouncer;

    localparam int         W    = 4;
    localparam int         D    = 8;
    localparam int         CW   = 4;
    localparam logic [W-1:0] INIT = '0;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] sw_out, sw_rise, sw_fall;
    logic         busy;

    switch_debouncer #(
        .WIDTH        (W),
        .DEBOUNCE_CNT (D),
        .CNT_W        (CW),
        .INIT_VAL     (INIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_in  (raw_in),
        .sw_out  (sw_out),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         busy;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] m_out;
    int           errors = 0;
    int           checks = 0;
    int           rise3_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a bit flips when the D+1 most recent synchronized samples
    // (raw taken at edges e-2-D .. e-2) all disagree with its current level.
    always @(posedge clk) begin : model
        exp_t         e;
        logic [W-1:0] nxt, r, f;
        bit           all_diff;
        if (!reset_n) begin
            hist.delete();
            for (int i = 0; i < D + 3; i++) hist.push_back(INIT);
            m_out = INIT;
            e = '{out: INIT, rise: '0, fall: '0, busy: 1'b0};
        end else begin
            hist.push_back(raw_in);
            void'(hist.pop_front());
            nxt = m_out;
            r = '0;
            f = '0;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int i = 0; i <= D; i++)
                    if (hist[i][b] == m_out[b]) all_diff = 1'b0;
                if (all_diff) begin
                    nxt[b] = ~m_out[b];
                    if (nxt[b]) r[b] = 1'b1;
                    else        f[b] = 1'b1;
                end
            end
            m_out = nxt;
            e = '{out: nxt, rise: r, fall: f, busy: |(hist[D] ^ nxt)};
        end
        exp_q.push_back(e);
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("sw_out",  32'(sw_out),  32'(e.out));
            check("sw_rise", 32'(sw_rise), 32'(e.rise));
            check("sw_fall", 32'(sw_fall), 32'(e.fall));
            check("busy",    32'(busy),    32'(e.busy));
        end
        if (sw_rise[3]) rise3_cnt++;
    end

    task automatic hold(input logic [W-1:0] v, input int n);
        raw_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Edge 0 is the first posedge after raw_in changed at the current negedge.
    task automatic measure(input string name, input int bi, input logic val, input int want);
        int hit = -1;
        for (int i = 0; i <= D + 6; i++) begin
            @(posedge clk);
            #1;
            if (hit < 0 && sw_out[bi] === val) hit = i;
        end
        check(name, 32'(hit), 32'(want));
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] v;
        int           calm;
        repeat (3) @(negedge clk);
        check("reset_out", 32'(sw_out), 32'(INIT));
        reset_n = 1'b1;
        hold('0, 3);

        raw_in = 4'b0001;
        measure("clean_latency", 0, 1'b1, D + 2);
        hold(4'b0001, 6);
        raw_in = 4'b0000;
        measure("release_latency", 0, 1'b0, D + 2);
        hold(4'b0000, 6);

        hold(4'b0010, 5); hold(4'b0000, 2); hold(4'b0010, 5); hold(4'b0000, 14);
        check("bounce_no_change", 32'(sw_out[1]), 32'd0);

        raw_in = 4'b1111;
        measure("simul_latency", 3, 1'b1, D + 2);
        check("simul_all", 32'(sw_out), 32'hF);
        hold(4'b1111, 4);
        hold(4'b0000, 16);

        // Reset lands when the settle counter holds 5 (after edge 7).
        raw_in = 4'b0100;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("reset_async_out", 32'({sw_out, sw_rise, sw_fall}), 32'd0);
        check("reset_async_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        measure("reset_latency", 2, 1'b1, D + 2);
        hold(4'b0100, 4);
        hold(4'b0000, 16);

        rise3_cnt = 0;
        hold(4'b1000, D);     hold(4'b0000, 16);
        check("threshold_short", 32'(rise3_cnt), 32'd0);
        hold(4'b1000, D + 1); hold(4'b0000, 20);
        check("threshold_long", 32'(rise3_cnt), 32'd1);

        calm = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) calm = $urandom_range(0, 1);
            v = raw_in;
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, calm ? 19 : 4) == 0) v[b] = ~v[b];
            raw_in = v;
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
            end
            @(negedge clk);
        end
        hold('0, 20);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
